par_to_ser_reg: RTL and testbench
=================================

// Module: par_to_ser_reg
// PURPOSE
//  Parallel-in/serial-out word shifter with valid/ready handshakes on both sides.
//  - Accepts a WIDTH x HEIGHT word array in one cycle.
//  - Emits one HEIGHT-bit word per accepted output handshake, oldest word (index WIDTH-1) first.
//  - Inverse of our serial-in delay line: feed out into a shift_N_reg of equal WIDTH/HEIGHT,
//    one shift per handshake; after WIDTH handshakes its out array equals the loaded array.
// PARAMETERS
//  WIDTH   4  number of words per load (>=1)
//  HEIGHT  1  bits per word (>=1)
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high reset
//  load_valid in   1               load_data is valid
//  load_ready out  1               block can accept a load this cycle
//  load_data  in   [WIDTH-1:0][HEIGHT-1:0]  word array; [WIDTH-1] is sent first
//  out_valid  out  1               out holds a valid word
//  out_ready  in   1               consumer takes out this cycle
//  out        out  HEIGHT          current serial word
//  busy       out  1               a load is in progress (words remain)
//  out_last   out  1               only with PAR_TO_SER_LAST_EN
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - State:
//    - FSM states: IDLE, SHIFT.
//    - buf[WIDTH-1:0][HEIGHT-1:0] holds the loaded words.
//    - cnt is $clog2(WIDTH+1) bits wide and holds the number of words remaining.
//  - Reset (async, held while asserted):
//    - state=IDLE, buf=0, cnt=0.
//    - Outputs: out_valid=0, out=0, busy=0, load_ready=1, out_last=0.
//  - Combinational outputs:
//    - out = buf[WIDTH-1].
//    - out_valid = busy = (state==SHIFT).
//    - load_ready = (state==IDLE) | (state==SHIFT & cnt==1 & out_ready).
//  - Load handshake (load_valid & load_ready):
//    - Next edge: buf<=load_data, cnt<=WIDTH, state<=SHIFT.
//    - The first word is visible on out the cycle after the load (1-cycle latency).
//  - Out handshake (out_valid & out_ready):
//    - Next edge: buf[i+1]<=buf[i] for all i, buf[0]<=0, cnt<=cnt-1.
//    - If cnt==1 and no simultaneous load: state<=IDLE.
//  - Back-to-back: final-word handshake plus load in the same cycle.
//    - The load wins: buf<=load_data, cnt<=WIDTH, state stays SHIFT.
//    - No idle bubble between loads.
//  - Stall: out_ready=0 holds out, buf and cnt stable indefinitely.
//  - Loads while busy (cnt>1) are not accepted; load_ready=0 and load_data is ignored.
//  - In IDLE, out=0 because zeros were shifted in; out_valid=0 regardless of out_ready.
//  - WIDTH=1: each load produces exactly one word; cnt is always 1 while in SHIFT.
//  - Reset mid-stream: all pending words are discarded immediately; the next load starts fresh.
//  - No combinational path from load_valid to any output.
// CONFIGURATION
//  PAR_TO_SER_LAST_EN defined:
//    - Adds output out_last = (state==SHIFT & cnt==1), marking the final word of each load.
//    - Reset value 0.
//  PAR_TO_SER_LAST_EN undefined:
//    - No out_last port; the rest of the behaviour is identical.
// TESTING (WIDTH=4, HEIGHT=5)
//  1. Reset:
//     - Assert reset asynchronously mid-cycle.
//     - Expect out_valid=0, out=0, busy=0, load_ready=1 with no clock edge needed.
//  2. Single load, out_ready held 1:
//     - load_data = {5'h11,5'h02,5'h13,5'h04}.
//     - out = 11,02,13,04 on the 4 cycles after the load.
//     - Then out_valid=0, out=0.
//  3. Stall:
//     - Same load; drop out_ready after the first word for 3 cycles.
//     - out holds 02 and cnt holds 3; resume and finish with 13,04.
//  4. Back-to-back:
//     - Present a second load {1F,1E,1D,1C} during the final-word (04) handshake.
//     - Next cycle out=1F with out_valid still 1 (no bubble).
//  5. Busy load / reset mid-stream:
//     - load_valid=1 while cnt=3: no effect.
//     - Assert reset after the second word: out_valid=0 at once; the next load emits its own words.
//  6. Loopback into shift_N_reg#(4,5), clocked only on handshakes:
//     - Random data, random out_ready.
//     - After 4 words the receiver out equals load_data.
//     - With PAR_TO_SER_LAST_EN defined, out_last=1 only on the 4th word.

Source files
------------

// File: rtl/par_to_ser_reg.sv
// Parallel-in/serial-out word shifter with valid/ready handshakes on both sides.
// Optional out_last output is enabled by defining PAR_TO_SER_LAST_EN.
module par_to_ser_reg #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [WIDTH-1:0][HEIGHT-1:0]  load_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HEIGHT-1:0]             out,
`ifdef PAR_TO_SER_LAST_EN
    output logic                          busy,
    output logic                          out_last
`else
    output logic                          busy
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [WIDTH-1:0][HEIGHT-1:0]   buf_q, buf_d;

    logic in_shift;
    logic last_word;
    logic load_hs;
    logic out_hs;

    assign in_shift   = (state_q == SHIFT);
    assign last_word  = (cnt_q == CNT_W'(1));
    assign out        = buf_q[WIDTH-1];
    assign out_valid  = in_shift;
    assign busy       = in_shift;
    // Depends on out_ready only, so load_valid never reaches an output combinationally.
    assign load_ready = !in_shift || (last_word && out_ready);
    assign load_hs    = load_valid && load_ready;
    assign out_hs     = in_shift && out_ready;

`ifdef PAR_TO_SER_LAST_EN
    assign out_last = in_shift && last_word;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        if (out_hs) begin
            for (int i = WIDTH - 1; i > 0; i--) begin
                buf_d[i] = buf_q[i-1];
            end
            buf_d[0] = '0;
            cnt_d    = cnt_q - CNT_W'(1);
            if (last_word) begin
                state_d = IDLE;
            end
        end

        // A load coinciding with the final-word handshake overrides the shift.
        if (load_hs) begin
            buf_d   = load_data;
            cnt_d   = CNT_W'(WIDTH);
            state_d = SHIFT;
        end
    end

    // NOTE: the word buffer is reset too, because out is driven straight from it and must read 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_par_to_ser_reg.sv
// Scoreboard bench for par_to_ser_reg (WIDTH=4, HEIGHT=5) with a handshake-clocked receiver model.
module tb_par_to_ser_reg;

    localparam int W = 4;
    localparam int H = 5;

    typedef logic [W-1:0][H-1:0] arr_t;
    typedef struct {
        logic [H-1:0] w;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          out_ready = 1'b0;
    arr_t          load_data = '0;
    logic          load_ready;
    logic          out_valid;
    logic [H-1:0]  out;
    logic          busy;
`ifdef PAR_TO_SER_LAST_EN
    logic          out_last;
`endif

    par_to_ser_reg #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
`ifdef PAR_TO_SER_LAST_EN
        .busy       (busy),
        .out_last   (out_last)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    arr_t arr_q[$];
    arr_t rx;
    int   rx_cnt = 0;
    bit   rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and feeds the receiver model.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            rx_cnt = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h with empty scoreboard", out);
            end else begin
                e = exp_q.pop_front();
                check("word", 32'(out), 32'(e.w));
`ifdef PAR_TO_SER_LAST_EN
                check("out_last", 32'(out_last), 32'(e.last));
`endif
            end
            rx = {rx[W-2:0], out};
            rx_cnt++;
            if (rx_cnt == W) begin
                rx_cnt = 0;
                if (arr_q.size() != 0) check("loopback", 32'(rx), 32'(arr_q.pop_front()));
            end
        end
    end

    task automatic do_load(input arr_t data);
        bit accepted = 0;
        load_data  = data;
        load_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (load_ready) begin
                accepted = 1;
                for (int k = W - 1; k >= 0; k--) exp_q.push_back('{w: data[k], last: (k == 0)});
                arr_q.push_back(data);
            end
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: load_ready never rose, required 1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
`ifdef PAR_TO_SER_LAST_EN
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
`endif
    endtask

    localparam arr_t DATA_A = {5'h11, 5'h02, 5'h13, 5'h04};
    localparam arr_t DATA_B = {5'h1F, 5'h1E, 5'h1D, 5'h1C};
    localparam arr_t DATA_C = {5'h0A, 5'h15, 5'h07, 5'h18};

    initial begin
        // 1. Reset asserted from time 0; values must hold before any clock edge.
        #1;
        check_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 2. Single load with out_ready held high.
        out_ready = 1'b1;
        do_load(DATA_A);
        check("latency_first_word", 32'(out), 32'h11);
        check("latency_valid", 32'(out_valid), 32'd1);
        drain();
        check_idle("after_single");

        // 3. Stall after the first word.
        do_load(DATA_A);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_out", 32'(out), 32'h02);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_load_ready", 32'(load_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // 4. Back-to-back: second load accepted during the final-word handshake.
        do_load(DATA_A);
        do_load(DATA_B);
        check("b2b_out", 32'(out), 32'h1F);
        check("b2b_valid", 32'(out_valid), 32'd1);
        drain();
        check_idle("after_b2b");

        // 5. Load while busy is ignored; reset mid-stream discards pending words.
        do_load(DATA_A);
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        load_data  = {5'h01, 5'h01, 5'h01, 5'h01};
        load_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("busy_load_ready", 32'(load_ready), 32'd0);
            check("busy_out", 32'(out), 32'h02);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle("midstream_reset");
        exp_q.delete();
        arr_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_load(DATA_C);
        check("fresh_first_word", 32'(out), 32'h0A);
        drain();
        check_idle("after_fresh");

        // 6. Loopback with random data and random out_ready.
        rand_done = 0;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    arr_t d;
                    for (int k = 0; k < W; k++) d[k] = H'($urandom);
                    do_load(d);
                end
                drain();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    if (!rand_done) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("after_loopback");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("loopback_all_compared", 32'(arr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
